// File: rtl/cell_stack.sv
// Parametrised data stack: TOS held in a register, deeper cells spilled to one inferred block RAM.
// Optional full/empty guarding with sticky overflow/underflow flags: define CELL_STACK_GUARD_EN.
module cell_stack #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_W     = 8
) (
  input  logic                  CLK,
  input  logic                  resetn,
  input  logic                  op_valid,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  op_ready,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] tos,
  output logic [ADDR_W:0]       depth,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH_W   = ADDR_W + 1;
  localparam int RAM_CELLS = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CAP = DEPTH_W'(RAM_CELLS + 1);

  localparam logic [1:0] OP_NOP     = 2'b00;
  localparam logic [1:0] OP_PUSH    = 2'b01;
  localparam logic [1:0] OP_POP     = 2'b10;
  localparam logic [1:0] OP_REPLACE = 2'b11;

  typedef enum logic {IDLE, RD_WAIT} state_t;

  state_t                state_reg, state_next;
  logic [DATA_WIDTH-1:0] tos_reg, tos_next;
  logic [ADDR_W:0]       depth_reg, depth_next;
  logic                  empty_reg, full_reg;

  logic                  accept;
  logic                  push_blocked, pop_blocked;
  logic [ADDR_W:0]       depth_m1, depth_m2;

  logic                  ram_we;
  logic [ADDR_W-1:0]     ram_addr;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic [DATA_WIDTH-1:0] mem [RAM_CELLS];

  assign accept   = op_valid && (state_reg == IDLE);
  assign depth_m1 = depth_reg - DEPTH_W'(1);
  assign depth_m2 = depth_reg - DEPTH_W'(2);

`ifdef CELL_STACK_GUARD_EN
  logic ovf_reg, unf_reg;

  assign push_blocked = accept && (op == OP_PUSH) && full_reg;
  assign pop_blocked  = accept && (op == OP_POP) && empty_reg;

  // A fresh guard hit outranks a clear arriving in the same cycle.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      ovf_reg <= 1'b0;
      unf_reg <= 1'b0;
    end else begin
      ovf_reg <= push_blocked ? 1'b1 : (err_clr ? 1'b0 : ovf_reg);
      unf_reg <= pop_blocked  ? 1'b1 : (err_clr ? 1'b0 : unf_reg);
    end
  end

  assign overflow  = ovf_reg;
  assign underflow = unf_reg;
`else
  logic unused_err_clr;

  assign push_blocked   = 1'b0;
  assign pop_blocked    = 1'b0;
  assign unused_err_clr = err_clr;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    tos_next   = tos_reg;
    depth_next = depth_reg;
    ram_we     = 1'b0;
    ram_addr   = depth_m2[ADDR_W-1:0];
    case (state_reg)
      IDLE: begin
        if (accept) begin
          case (op)
            OP_PUSH: begin
              if (!push_blocked) begin
                if (depth_reg != '0) begin
                  ram_we   = 1'b1;
                  ram_addr = depth_m1[ADDR_W-1:0];
                end
                tos_next   = din;
                depth_next = depth_reg + DEPTH_W'(1);
              end
            end
            OP_POP: begin
              if (!pop_blocked) begin
                if (depth_reg == DEPTH_W'(1)) begin
                  tos_next   = '0;
                  depth_next = '0;
                end else begin
                  // Unguarded empty pop also lands here and wraps, like the old 8-bit pointer.
                  depth_next = depth_m1;
                  state_next = RD_WAIT;
                end
              end
            end
            OP_REPLACE: begin
              tos_next = din;
              if (depth_reg == '0) depth_next = DEPTH_W'(1);
            end
            OP_NOP: ;
            default: ;
          endcase
        end
      end
      RD_WAIT: begin
        tos_next   = ram_rdata;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE;
      tos_reg   <= '0;
      depth_reg <= '0;
      empty_reg <= 1'b1;
      full_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      tos_reg   <= tos_next;
      depth_reg <= depth_next;
      empty_reg <= (depth_next == '0);
      full_reg  <= (depth_next == CAP);
    end
  end

  // Spill RAM: single port, registered read, contents deliberately not reset.
  always_ff @(posedge CLK) begin
    if (ram_we) mem[ram_addr] <= tos_reg;
    ram_rdata <= mem[ram_addr];
  end

  assign op_ready = (state_reg == IDLE);
  assign tos      = tos_reg;
  assign depth    = depth_reg;
  assign empty    = empty_reg;
  assign full     = full_reg;

endmodule

// File: tb/tb_cell_stack.sv
// Directed self-checking bench for cell_stack (ADDR_W = 2, so capacity is 5 cells).
module tb_cell_stack;

  localparam int DW = 32;
  localparam int AW = 2;

  localparam logic [1:0] NOP = 2'b00;
  localparam logic [1:0] PSH = 2'b01;
  localparam logic [1:0] POP = 2'b10;
  localparam logic [1:0] REP = 2'b11;

  logic          CLK = 1'b0;
  logic          resetn = 1'b0;
  logic          op_valid = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [DW-1:0] din = '0;
  logic          op_ready;
  logic          err_clr = 1'b0;
  logic [DW-1:0] tos;
  logic [AW:0]   depth;
  logic          empty, full, overflow, underflow;

  int total = 0;
  int bad   = 0;

  cell_stack #(.DATA_WIDTH(DW), .ADDR_W(AW)) dut (
    .CLK(CLK), .resetn(resetn), .op_valid(op_valid), .op(op), .din(din),
    .op_ready(op_ready), .err_clr(err_clr), .tos(tos), .depth(depth),
    .empty(empty), .full(full), .overflow(overflow), .underflow(underflow)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One op presented for exactly one rising edge; returns 1 ns after that edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] d, input logic ec);
    @(negedge CLK);
    op_valid = 1'b1;
    op       = o;
    din      = d;
    err_clr  = ec;
    @(posedge CLK);
    #1;
    op_valid = 1'b0;
    err_clr  = 1'b0;
    $display("op=%0d din=%0h clr=%0b -> tos=%0h depth=%0d rdy=%0b", o, d, ec, tos, depth, op_ready);
  endtask

  task automatic settle_rd();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    resetn = 1'b0;
    @(negedge CLK);
    resetn = 1'b1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_tos"}, tos, 32'h0);
    chk({tag, "_depth"}, 32'(depth), 32'd0);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
    chk({tag, "_unf"}, 32'(underflow), 32'd0);
    chk({tag, "_rdy"}, 32'(op_ready), 32'd1);
  endtask

  initial begin
    #12;
    chk_reset_vals("rst");
    @(negedge CLK);
    resetn = 1'b1;

    // Three back-to-back pushes
    issue(PSH, 32'h11, 1'b0); chk("push1_rdy", 32'(op_ready), 32'd1);
    issue(PSH, 32'h22, 1'b0); chk("push2_rdy", 32'(op_ready), 32'd1);
    issue(PSH, 32'h33, 1'b0); chk("push3_rdy", 32'(op_ready), 32'd1);
    chk("push3_tos", tos, 32'h33);
    chk("push3_depth", 32'(depth), 32'd3);
    chk("push3_empty", 32'(empty), 32'd0);

    // Two long pops then one short pop
    issue(POP, 32'h0, 1'b0);
    chk("pop1_busy", 32'(op_ready), 32'd0);
    chk("pop1_depth", 32'(depth), 32'd2);
    settle_rd();
    chk("pop1_tos", tos, 32'h22);
    chk("pop1_rdy", 32'(op_ready), 32'd1);
    issue(POP, 32'h0, 1'b0);
    chk("pop2_busy", 32'(op_ready), 32'd0);
    chk("pop2_depth", 32'(depth), 32'd1);
    settle_rd();
    chk("pop2_tos", tos, 32'h11);
    chk("pop2_rdy", 32'(op_ready), 32'd1);
    issue(POP, 32'h0, 1'b0);
    chk("pop3_tos", tos, 32'h0);
    chk("pop3_depth", 32'(depth), 32'd0);
    chk("pop3_empty", 32'(empty), 32'd1);
    chk("pop3_rdy", 32'(op_ready), 32'd1);

    // Fill to capacity, then push once more
    for (int i = 1; i <= 5; i++) issue(PSH, 32'(i), 1'b0);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_depth", 32'(depth), 32'd5);
    chk("fill_tos", tos, 32'h5);
    issue(PSH, 32'h6, 1'b0);
`ifdef CELL_STACK_GUARD_EN
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_tos", tos, 32'h5);
    chk("ovf_depth", 32'(depth), 32'd5);
    chk("ovf_full", 32'(full), 32'd1);
    issue(NOP, 32'h0, 1'b1);
    chk("ovf_clr", 32'(overflow), 32'd0);
    issue(POP, 32'h0, 1'b0);
    settle_rd();
    chk("ovf_pop_tos", tos, 32'h4);
`else
    chk("wrap_ovf", 32'(overflow), 32'd0);
    chk("wrap_tos", tos, 32'h6);
    chk("wrap_depth", 32'(depth), 32'd6);
    chk("wrap_full", 32'(full), 32'd0);
`endif
    do_reset();
    chk("rst2_depth", 32'(depth), 32'd0);

    // Pop on an empty stack
    issue(POP, 32'h0, 1'b0);
`ifdef CELL_STACK_GUARD_EN
    chk("unf_set", 32'(underflow), 32'd1);
    chk("unf_depth", 32'(depth), 32'd0);
    chk("unf_rdy", 32'(op_ready), 32'd1);
    issue(POP, 32'h0, 1'b1);
    chk("unf_set_wins", 32'(underflow), 32'd1);
    issue(NOP, 32'h0, 1'b1);
    chk("unf_clr", 32'(underflow), 32'd0);
`else
    // RAM[(0-2) mod 4] = RAM[2] still holds 3 from the fill above
    chk("epop_unf", 32'(underflow), 32'd0);
    chk("epop_depth", 32'(depth), 32'd7);
    chk("epop_busy", 32'(op_ready), 32'd0);
    settle_rd();
    chk("epop_tos", tos, 32'h3);
`endif
    do_reset();

    // REPLACE never touches RAM
    issue(PSH, 32'hA, 1'b0);
    issue(PSH, 32'hB, 1'b0);
    issue(REP, 32'hC, 1'b0);
    chk("rep_tos", tos, 32'hC);
    chk("rep_depth", 32'(depth), 32'd2);
    issue(POP, 32'h0, 1'b0);
    settle_rd();
    chk("rep_pop_tos", tos, 32'hA);
    chk("rep_pop_depth", 32'(depth), 32'd1);
    issue(POP, 32'h0, 1'b0);
    issue(REP, 32'h55, 1'b0);
    chk("rep_empty_tos", tos, 32'h55);
    chk("rep_empty_depth", 32'(depth), 32'd1);

    // PUSH held through RD_WAIT is taken at N+2 and spills the freshly loaded TOS
    issue(PSH, 32'h66, 1'b0);
    @(negedge CLK);
    op_valid = 1'b1; op = POP; din = 32'h0;
    @(posedge CLK); #1;
    op = PSH; din = 32'h77;
    @(posedge CLK); #1;
    chk("hold_tos", tos, 32'h55);
    chk("hold_depth", 32'(depth), 32'd1);
    chk("hold_rdy", 32'(op_ready), 32'd1);
    @(posedge CLK); #1;
    op_valid = 1'b0;
    $display("op=held-push din=77 -> tos=%0h depth=%0d rdy=%0b", tos, depth, op_ready);
    chk("held_push_tos", tos, 32'h77);
    chk("held_push_depth", 32'(depth), 32'd2);
    issue(POP, 32'h0, 1'b0);
    settle_rd();
    chk("held_pop_tos", tos, 32'h55);

    // Asynchronous reset during RD_WAIT
    issue(PSH, 32'h2, 1'b0);
    issue(POP, 32'h0, 1'b0);
    chk("rdw_busy", 32'(op_ready), 32'd0);
    #2;
    resetn = 1'b0;
    #1;
    chk_reset_vals("arst");
    @(posedge CLK); #1;
    chk("arst_hold_tos", tos, 32'h0);
    @(negedge CLK);
    resetn = 1'b1;
    issue(PSH, 32'h7, 1'b0);
    chk("arst_push_tos", tos, 32'h7);
    chk("arst_push_depth", 32'(depth), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
